// File: rtl/adder_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_ctrl_pkg                                                       |
// | Shared FSM encodings and slice width for the nibble-serial adder.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package adder_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of the shared ripple slice
  localparam int NIB = 4;

endpackage
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl_fa4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | FA_4_Ripple                                                          |
// | Four full adders chained LSB to MSB; purely combinational slice.     |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module FA_4_Ripple
  import adder_ctrl_pkg::*;
(
  input  logic [NIB-1:0] a,
  input  logic [NIB-1:0] b,
  input  logic           cin,
  output logic [NIB-1:0] s,
  output logic           cout3
);

  logic [NIB:0] w_c;

  assign w_c[0] = cin;

  // One full adder per bit, carry rippling upward
  generate
    for (genvar i = 0; i < NIB; i++) begin : g_bit
      assign s[i]     = a[i] ^ b[i] ^ w_c[i];
      assign w_c[i+1] = (a[i] & b[i]) | (a[i] & w_c[i]) | (b[i] & w_c[i]);
    end
  endgenerate

  assign cout3 = w_c[NIB];

endmodule
`default_nettype wire

// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nibble_serial_adder_ctrl                                             |
// | Adds or subtracts WIDTH-bit operands one nibble per clock, LSB       |
// | first, through a single shared 4-bit ripple slice.                   |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module nibble_serial_adder_ctrl
  import adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIB;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] c_idx_last = IDX_W'(NIBBLES - 1);

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_out_valid;

  logic [NIB-1:0]   w_s;
  logic             w_c;
  logic             w_go;
  logic             w_last;
  logic             w_take;

  assign w_go   = in_valid && (r_state == ST_IDLE);
  assign w_last = (r_state == ST_RUN) && (r_idx == c_idx_last);
  assign w_take = r_out_valid && out_ready;

  // Shared slice sees only registered operands and the registered carry
  FA_4_Ripple u_slice (
    .a     (r_a[r_idx*NIB +: NIB]),
    .b     (r_bx[r_idx*NIB +: NIB]),
    .cin   (r_carry),
    .s     (w_s),
    .cout3 (w_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: accept, run all nibbles, hold until consumed
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_go)   w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last) w_state_nxt = ST_DONE;
      ST_DONE: if (w_take) w_state_nxt = ST_IDLE;
      default:             w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded handshake/status outputs
  always_comb begin
    in_ready = (r_state == ST_IDLE);
    busy     = (r_state == ST_RUN);
  end

  // Operand capture, per-nibble accumulation and final flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_bx    <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_go) begin
      r_a     <= op_a;
      r_bx    <= sub ? ~op_b : op_b;
      r_carry <= sub ? 1'b1 : cin;
      r_idx   <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum[r_idx*NIB +: NIB] <= w_s;
      r_carry                 <= w_c;
      if (w_last) begin
        r_idx  <= '0;
        r_cout <= w_c;
        // Top slice bit is the result MSB; overflow needs like-signed operands
        r_ovf  <= (r_a[WIDTH-1] == r_bx[WIDTH-1]) && (w_s[NIB-1] != r_a[WIDTH-1]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  // Result-valid register: asserts one cycle into DONE, drops on consume
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_valid <= 1'b0;
    else        r_out_valid <= (r_state == ST_DONE) && !w_take;
  end

  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nibble_serial_adder_ctrl                                          |
// | Directed vectors with hand-computed results for the serial adder.    |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_nibble_serial_adder_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid after an accept edge; returns edges counted (0 = timeout)
  task automatic wait_valid(output int lat);
    lat = 0;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = e;
        break;
      end
    end
  endtask

  // One complete operation from IDLE through consume
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic ci, input logic sb,
                       input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    op_a = a; op_b = b; cin = ci; sub = sb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, " busy"}, busy, 1);
    check({tag, " in_ready_run"}, in_ready, 0);
    wait_valid(lat);
    check({tag, " latency"}, lat, 5);
    check({tag, " sum"}, sum, es);
    check({tag, " cout"}, cout, ec);
    check({tag, " ovf"}, ovf, eo);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, " valid_drop"}, out_valid, 0);
    check({tag, " in_ready_back"}, in_ready, 1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op_a = '0; op_b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst busy", busy, 0);
    check("rst sum", sum, 16'h0000);
    check("rst cout", cout, 0);
    check("rst ovf", ovf, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("add1",   16'h1234, 16'h0001, 1'b0, 1'b0, 16'h1235, 1'b0, 1'b0);
    do_op("addff",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_op("addovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("addcin", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op("sub57",  16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_op("sub75",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);
    do_op("subovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    do_op("mixadd", 16'hA5C3, 16'h5A3D, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0);

    // Backpressure: result held while a new request is pending
    op_a = 16'h1234; op_b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    op_a = 16'hAAAA; op_b = 16'h5555;
    wait_valid(lat);
    check("bp latency", lat, 5);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("bp sum", sum, 16'h1235);
      check("bp cout", cout, 0);
      check("bp ovf", ovf, 0);
      check("bp in_ready", in_ready, 0);
      check("bp out_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp idle in_ready", in_ready, 1);
    check("bp idle out_valid", out_valid, 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp reaccept busy", busy, 1);
    wait_valid(lat);
    check("bp2 latency", lat, 5);
    check("bp2 sum", sum, 16'hFFFF);
    check("bp2 cout", cout, 0);
    check("bp2 ovf", ovf, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset abandons an operation two cycles into RUN
    op_a = 16'h1111; op_b = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    check("midrun busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst busy", busy, 0);
    check("midrst sum", sum, 16'h0000);
    check("midrst in_ready", in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("postrst", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global time limit so the run always ends on its own
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
